// File: rtl/lvds_deser_pkg.sv
// Constants and helpers shared by the LVDS deserializer blocks.
// NB() gives the number of bytes that make up one output word.
package lvds_deser_pkg;

    localparam int BYTE_W = 8;

    function automatic int NB(input int word_size);
        return word_size / BYTE_W;
    endfunction

endpackage

// File: rtl/lvds_byte_capture.sv
// Behavioral 1:8 DDR capture: the differential input is sampled on both clk_bit edges.
// One byte is presented per clk_div period, and the earliest bit lands in q[7].
module lvds_byte_capture
    import lvds_deser_pkg::*;
(
    input  logic              rst,
    input  logic              clk_bit,
    input  logic              clk_div,
    input  logic              din_p,
    input  logic              din_n,
    output logic [BYTE_W-1:0] q
);

    logic              w_din;
    logic              r_rise;
    logic              r_fall;
    logic [BYTE_W-3:0] r_pairs;
    logic [BYTE_W-1:0] w_bits;

    // Differential receiver: the bit is 1 only when the positive leg is high and the negative leg is low.
    assign w_din  = din_p & ~din_n;
    assign w_bits = {r_pairs, r_rise, r_fall};

    always_ff @(negedge clk_bit or posedge rst) begin
        if (rst) r_fall <= 1'b0;
        else     r_fall <= w_din;
    end

    // Each rising edge appends the previous rise/fall pair to the history.
    // When clk_div rises, w_bits therefore holds the last eight edges, oldest bit first.
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            r_rise  <= 1'b0;
            r_pairs <= '0;
        end else begin
            r_rise  <= w_din;
            r_pairs <= w_bits[BYTE_W-3:0];
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) q <= '0;
        else     q <= w_bits;
    end

endmodule

// File: rtl/lvds_word_deser.sv
// LVDS word deserializer: DDR byte capture, a clk_div byte chain, and a hold register.
// The hold register is loaded on each fclk frame edge and presented on dout at the next fclk edge.
module lvds_word_deser
    import lvds_deser_pkg::*;
#(
    parameter int    DEV_W       = 8,
    parameter int    WORD_SIZE   = 24,
    parameter string IOSTANDARD  = "LVDS_25",
    parameter real   REFCLK_FREQ = 200.0
) (
    input  logic                 clk_div,
    input  logic                 rst,
    input  logic                 clk_bit,
    input  logic                 fclk,
    input  logic                 din_p,
    input  logic                 din_n,
    output logic [WORD_SIZE-1:0] dout
);

    localparam int NUM_B = NB(WORD_SIZE);

    if (DEV_W != 8 || (WORD_SIZE % BYTE_W) != 0) begin : g_bad_cfg
        $error("lvds_word_deser: unsupported DEV_W=%0d WORD_SIZE=%0d (IOSTANDARD=%s REFCLK_FREQ=%f)",
               DEV_W, WORD_SIZE, IOSTANDARD, REFCLK_FREQ);
    end

    logic [BYTE_W-1:0]    w_q;
    logic [WORD_SIZE-1:0] w_word;
    logic [1:0]           r_fclk_sr;
    logic                 w_frame_edge;
    logic [WORD_SIZE-1:0] r_hold;

    lvds_byte_capture u_capture (
        .rst     (rst),
        .clk_bit (clk_bit),
        .clk_div (clk_div),
        .din_p   (din_p),
        .din_n   (din_n),
        .q       (w_q)
    );

    // r_d packs d(NB-1)..d1, so shifting in q is just keeping the low bytes of the word.
    if (NUM_B > 1) begin : g_chain
        logic [(NUM_B-1)*BYTE_W-1:0] r_d;

        assign w_word = {r_d, w_q};

        always_ff @(posedge clk_div or posedge rst) begin
            if (rst) r_d <= '0;
            else     r_d <= w_word[(NUM_B-1)*BYTE_W-1:0];
        end
    end else begin : g_single
        assign w_word = w_q;
    end

    assign w_frame_edge = (r_fclk_sr == 2'b01);

    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            r_fclk_sr <= '0;
            r_hold    <= '0;
        end else begin
            r_fclk_sr <= {r_fclk_sr[0], fclk};
            if (w_frame_edge) r_hold <= w_word;
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) dout <= '0;
        else     dout <= r_hold;
    end

endmodule

// File: tb/tb_lvds_word_deser.sv
// Self-checking bench for lvds_word_deser: 24-bit and 16-bit instances share clocks and reset.
// A byte-level model predicts dout: each fclk edge latches the last NB completed bytes, and dout shows the word latched at the previous edge.
module tb_lvds_word_deser;

    // ---------------- clock / reset ----------------
    logic clk_bit = 1'b0;
    logic clk_div = 1'b0;
    logic rst     = 1'b1;
    int   per     = -1;
    int   rise_cnt = 0;

    initial begin
        forever begin
            #4 clk_bit = 1'b1;
            if (rise_cnt % 4 == 0) begin
                per     = per + 1;
                clk_div = 1'b1;
            end else if (rise_cnt % 4 == 2) begin
                clk_div = 1'b0;
            end
            rise_cnt = rise_cnt + 1;
            #4 clk_bit = 1'b0;
        end
    end

    // ---------------- DUTs ----------------
    logic        fclk24 = 1'b0;
    logic        fclk16 = 1'b0;
    logic        din24_p = 1'b0, din24_n = 1'b1;
    logic        din16_p = 1'b0, din16_n = 1'b1;
    logic [23:0] dout24;
    logic [15:0] dout16;

    lvds_word_deser #(.WORD_SIZE(24)) u_dut24 (
        .clk_div (clk_div),
        .rst     (rst),
        .clk_bit (clk_bit),
        .fclk    (fclk24),
        .din_p   (din24_p),
        .din_n   (din24_n),
        .dout    (dout24)
    );

    lvds_word_deser #(.WORD_SIZE(16)) u_dut16 (
        .clk_div (clk_div),
        .rst     (rst),
        .clk_bit (clk_bit),
        .fclk    (fclk16),
        .din_p   (din16_p),
        .din_n   (din16_n),
        .dout    (dout16)
    );

    // ---------------- stimulus control ----------------
    int pat      = 0;    // 0: frame pattern, 1: constant ones, 2: constant zeros
    bit fclk_run = 1'b1;

    // The frame starts with the period whose index is a multiple of the frame length.
    initial begin
        forever begin
            @(posedge clk_div);
            #1;
            fclk24 = fclk_run && (per % 3 == 0);
            fclk16 = fclk_run && (per % 2 == 0);
        end
    end

    function automatic logic [7:0] pat_byte(input int mode, input int nb, input int k);
        logic [7:0] b;
        case (mode)
            1:       b = 8'hFF;
            2:       b = 8'h00;
            default: begin
                if (nb == 3) begin
                    case (k % 3)
                        0:       b = 8'hA5;
                        1:       b = 8'h3C;
                        default: b = 8'h0F;
                    endcase
                end else begin
                    b = (k % 2 == 0) ? 8'h12 : 8'h34;
                end
            end
        endcase
        return b;
    endfunction

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_q24[$];
    logic [7:0]  exp_q16[$];
    logic [23:0] hold24_m = '0, exp24 = '0;
    logic [15:0] hold16_m = '0, exp16 = '0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: the loop runs 2 time units ahead of each bit edge, and each call covers one clk_div period (MSB first).
    task automatic send_period();
        int k;
        logic [7:0] b24, b16;
        k   = per + 1;
        b24 = pat_byte(pat, 3, k);
        b16 = pat_byte(pat, 2, k);
        if (rst) begin
            exp_q24.delete();
            exp_q16.delete();
        end else begin
            exp_q24.push_back(b24);
            exp_q16.push_back(b16);
            if (exp_q24.size() > 8) void'(exp_q24.pop_front());
            if (exp_q16.size() > 8) void'(exp_q16.pop_front());
        end
        for (int j = 7; j >= 0; j--) begin
            din24_p = b24[j];
            din24_n = ~b24[j];
            din16_p = b16[j];
            din16_n = ~b16[j];
            #4;
        end
    endtask

    initial begin
        @(posedge clk_div);
        #30;
        forever send_period();
    end

    always @(posedge rst) begin
        exp_q24.delete();
        exp_q16.delete();
        hold24_m = '0;
        hold16_m = '0;
        exp24    = '0;
        exp16    = '0;
    end

    // The newest queue entry is the period that is still in progress, so it is skipped.
    always @(posedge fclk24) begin
        if (!rst) begin
            exp24    = hold24_m;
            hold24_m = '0;
            for (int i = 1; i <= 3; i++)
                if (exp_q24.size() > i) hold24_m[8*(i-1) +: 8] = exp_q24[exp_q24.size()-1-i];
        end
    end

    always @(posedge fclk16) begin
        if (!rst) begin
            exp16    = hold16_m;
            hold16_m = '0;
            for (int i = 1; i <= 2; i++)
                if (exp_q16.size() > i) hold16_m[8*(i-1) +: 8] = exp_q16[exp_q16.size()-1-i];
        end
    end

    always @(posedge clk_div) begin
        #5;
        check("model_dout24", dout24, exp24);
        check("model_dout16", {8'h00, dout16}, {8'h00, exp16});
    end

    // ---------------- directed sequence ----------------
    task automatic release_rst();
        repeat (2) @(posedge clk_div);
        do @(posedge clk_div); while (per % 6 != 5);
        #29 rst = 1'b0;
    endtask

    task automatic wait_periods(input int n);
        repeat (n) @(posedge clk_div);
        #5;
    endtask

    initial begin
        rst      = 1'b1;
        pat      = 0;
        fclk_run = 1'b1;

        wait_periods(6);
        check("in_reset_dout24", dout24, 24'h000000);
        check("in_reset_dout16", {8'h00, dout16}, 24'h001234 & 24'h0);
        release_rst();

        wait_periods(12);
        check("frame_a53c0f", dout24, 24'hA53C0F);
        check("frame_1234", {8'h00, dout16}, 24'h001234);

        @(posedge clk_div);
        #9 rst = 1'b1;
        #1;
        check("midframe_rst_dout24", dout24, 24'h000000);
        check("midframe_rst_dout16", {8'h00, dout16}, 24'h000000);
        release_rst();
        wait_periods(12);
        check("after_rst_a53c0f", dout24, 24'hA53C0F);
        check("after_rst_1234", {8'h00, dout16}, 24'h001234);

        @(posedge clk_div);
        fclk_run = 1'b0;
        pat      = 1;
        wait_periods(12);
        check("fclk_low_hold24", dout24, 24'hA53C0F);
        check("fclk_low_hold16", {8'h00, dout16}, 24'h001234);

        @(posedge clk_div);
        fclk_run = 1'b1;
        wait_periods(12);
        check("ones_dout24", dout24, 24'hFFFFFF);
        check("ones_dout16", {8'h00, dout16}, 24'h00FFFF);

        @(posedge clk_div);
        pat = 2;
        wait_periods(12);
        check("zeros_dout24", dout24, 24'h000000);
        check("zeros_dout16", {8'h00, dout16}, 24'h000000);

        @(posedge clk_div);
        pat      = 0;
        fclk_run = 1'b0;
        #9 rst = 1'b1;
        release_rst();
        wait_periods(12);
        check("fclk_low_after_rst24", dout24, 24'h000000);
        check("fclk_low_after_rst16", {8'h00, dout16}, 24'h000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
